// File: rtl/uart_rx.sv
// 8N1 UART receiver: double-synchronised line, centre sampling, byte held with
// ready / framing-error / overrun flags until the consumer acknowledges it.
module uart_rx #(
    parameter int BAUD_TIME   = 2604,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       clr_rdy,
    output logic [7:0] rx_data,
    output logic       rx_rdy,
    output logic       frm_err,
    output logic       ovr
);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    localparam logic [11:0] HALF_M1 = 12'(BAUD_TIME / 2 - 1);
    localparam logic [11:0] FULL_M1 = 12'(BAUD_TIME - 1);

    state_t                 state;
    logic [SYNC_STAGES-1:0] rx_sync;
    logic                   rx_s;
    logic [11:0]            bd_cnt;
    logic [3:0]             bit_cnt;
    logic [7:0]             shift;
    logic                   stop_vld_p1;
    logic                   stop_ok_p1;

    assign rx_s = rx_sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_sync     <= '1;
            state       <= IDLE;
            bd_cnt      <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            stop_vld_p1 <= 1'b0;
            stop_ok_p1  <= 1'b0;
            rx_data     <= 8'h00;
            rx_rdy      <= 1'b0;
            frm_err     <= 1'b0;
            ovr         <= 1'b0;
        end else begin
            rx_sync     <= {rx_sync[SYNC_STAGES-2:0], rx};
            stop_vld_p1 <= 1'b0;

            case (state)
                IDLE: begin
                    bd_cnt <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (bd_cnt == HALF_M1) begin
                        bd_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end
                    end else begin
                        bd_cnt <= bd_cnt + 12'd1;
                    end
                end
                DATA: begin
                    if (bd_cnt == FULL_M1) begin
                        bd_cnt  <= '0;
                        shift   <= {rx_s, shift[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) state <= STOP;
                    end else begin
                        bd_cnt <= bd_cnt + 12'd1;
                    end
                end
                STOP: begin
                    // Leaving at mid-stop lets a start bit that follows immediately be caught.
                    if (bd_cnt == FULL_M1) begin
                        bd_cnt      <= '0;
                        stop_vld_p1 <= 1'b1;
                        stop_ok_p1  <= rx_s;
                        state       <= rx_s ? IDLE : BRK;
                    end else begin
                        bd_cnt <= bd_cnt + 12'd1;
                    end
                end
                BRK: begin
                    bd_cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    bd_cnt <= '0;
                end
            endcase

            // p1 -> outputs: publish the stop-bit verdict one cycle after sampling
            if (stop_vld_p1 && stop_ok_p1) begin
                rx_data <= shift;
                rx_rdy  <= 1'b1;
                frm_err <= 1'b0;
                ovr     <= clr_rdy ? 1'b0 : (ovr | rx_rdy);
            end else begin
                if (stop_vld_p1) frm_err <= 1'b1;
                if (clr_rdy) begin
                    rx_rdy <= 1'b0;
                    ovr    <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames, compared against a
// frame-level model of the received byte and its flags.
module tb_uart_rx;

    localparam int BT = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rx_rdy;
    logic       frm_err;
    logic       ovr;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_data;
    logic       m_rdy;
    logic       m_frm;
    logic       m_ovr;

    logic       rdy_q = 1'b0;
    int         rdy_rises = 0;
    logic [7:0] b2b [4] = '{8'h00, 8'hFF, 8'h55, 8'h80};

    uart_rx #(.BAUD_TIME(BT), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rx_rdy  (rx_rdy),
        .frm_err (frm_err),
        .ovr     (ovr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_rdy === 1'b1 && rdy_q !== 1'b1) rdy_rises++;
        rdy_q = rx_rdy;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_data"}, 32'(rx_data), 32'(m_data));
        chk({tag, "_rdy"},  32'(rx_rdy),  32'(m_rdy));
        chk({tag, "_frm"},  32'(frm_err), 32'(m_frm));
        chk({tag, "_ovr"},  32'(ovr),     32'(m_ovr));
    endtask

    // A frame is 10 bit times on the line; a low stop may be stretched into a break.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int hold_bits);
        rx = 1'b0;
        repeat (BT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (BT) @(negedge clk);
        end
        rx = stop;
        repeat (BT) @(negedge clk);
        if (!stop) repeat (hold_bits * BT) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic model_frame(input logic [7:0] b, input logic stop);
        if (stop) begin
            m_ovr  = m_ovr | m_rdy;
            m_rdy  = 1'b1;
            m_data = b;
            m_frm  = 1'b0;
        end else begin
            m_frm = 1'b1;
        end
    endtask

    task automatic ack();
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        m_rdy = 1'b0;
        m_ovr = 1'b0;
    endtask

    initial begin
        int lat;
        int r0;
        rst = 1'b1; rx = 1'b1; clr_rdy = 1'b0;
        m_data = 8'h00; m_rdy = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // pin-to-ready latency on 0xA5
        lat = 0;
        fork
            send_frame(8'hA5, 1'b1, 0);
            begin
                @(posedge clk); #1;
                while (rx_rdy !== 1'b1 && lat < 400) begin
                    @(posedge clk); #1;
                    lat++;
                end
            end
        join
        chk("latency", 32'(lat), 32'd155);
        model_frame(8'hA5, 1'b1);
        check_all("a5");
        ack();
        check_all("a5_ack");

        // back-to-back frames, acked mid-way through the following frame
        fork
            for (int j = 0; j < 4; j++) send_frame(b2b[j], 1'b1, 0);
            for (int j = 0; j < 4; j++) begin
                repeat (157) @(negedge clk);
                model_frame(b2b[j], 1'b1);
                check_all("b2b");
                ack();
                repeat (2) @(negedge clk);
            end
        join
        repeat (BT) @(negedge clk);
        check_all("b2b_end");

        // short low glitch on idle line
        r0 = rdy_rises;
        rx = 1'b0;
        repeat (6) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BT) @(negedge clk);
        chk("glitch_rises", 32'(rdy_rises - r0), 32'd0);
        check_all("glitch");

        // bad stop followed by a long break, then a good frame
        r0 = rdy_rises;
        send_frame(8'h3C, 1'b0, 40);
        model_frame(8'h3C, 1'b0);
        repeat (BT) @(negedge clk);
        chk("break_rises", 32'(rdy_rises - r0), 32'd0);
        check_all("break");
        send_frame(8'h12, 1'b1, 0);
        model_frame(8'h12, 1'b1);
        check_all("after_break");
        ack();

        // overrun, ack, and ack coinciding with completion
        send_frame(8'h11, 1'b1, 0);
        model_frame(8'h11, 1'b1);
        check_all("ovr_first");
        send_frame(8'h22, 1'b1, 0);
        model_frame(8'h22, 1'b1);
        check_all("ovr_second");
        ack();
        check_all("ovr_ack");
        send_frame(8'h33, 1'b1, 0);
        model_frame(8'h33, 1'b1);
        check_all("pre_coincide");
        fork
            send_frame(8'h44, 1'b1, 0);
            begin
                repeat (155) @(negedge clk);
                clr_rdy = 1'b1;
                @(negedge clk);
                clr_rdy = 1'b0;
            end
        join
        m_data = 8'h44; m_rdy = 1'b1; m_ovr = 1'b0; m_frm = 1'b0;
        check_all("coincide");

        // reset during data bit 4 while a byte is still pending
        send_frame(8'h5A, 1'b1, 0);
        model_frame(8'h5A, 1'b1);
        rx = 1'b0;
        repeat (BT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = i[0];
            repeat (BT) @(negedge clk);
        end
        rx = 1'b0;
        repeat (BT / 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx = 1'b1;
        m_data = 8'h00; m_rdy = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
        check_all("rst");
        r0 = rdy_rises;
        repeat (2 * BT) @(negedge clk);
        send_frame(8'h7E, 1'b1, 0);
        model_frame(8'h7E, 1'b1);
        check_all("after_rst");
        chk("rst_rises", 32'(rdy_rises - r0), 32'd1);
        ack();

        // random frames, stop bits, breaks, gaps and acks
        for (int n = 0; n < 20; n++) begin
            logic [7:0] b;
            logic       stop;
            int         gap;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(b, stop, stop ? 0 : int'($urandom_range(0, 3)));
            model_frame(b, stop);
            check_all("rand");
            gap = stop ? int'($urandom_range(0, 40)) : int'($urandom_range(4, 40));
            if ($urandom_range(0, 1) == 1 && gap >= 2) begin
                ack();
                chk("rand_ack_rdy", 32'(rx_rdy), 32'd0);
                gap = gap - 1;
            end
            repeat (gap) @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; receive-side counterpart to the team's uart_tx.
- Recovers 8N1 frames (start bit 0, 8 data bits LSB first, stop bit 1) from a serial line.
- Samples each bit at its centre and presents the byte with a ready flag, framing-error flag and overrun flag to the consuming logic (command parser / SNN input loader).

Parameters:
- BAUD_TIME, 2604, clock cycles per bit (50 MHz / 19200 baud); must be even and >= 8.
- SYNC_STAGES, 2, number of metastability flops on rx; must be >= 2.

Ports:
- clk  input  1  system clock, 50 MHz.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- rx  input  1  asynchronous serial line; idles high.
- clr_rdy  input  1  consumer acknowledge; clears rx_rdy and ovr.
- rx_data  output  8  last good received byte.
- rx_rdy  output  1  high while an unacknowledged good byte is held.
- frm_err  output  1  high when the last frame had stop bit = 0.
- ovr  output  1  sticky overrun: a good byte completed while rx_rdy was already 1.

Behaviour:
- Reset (synchronous): state=IDLE, sync flops=1, bd_cnt=0, bit_cnt=0, shift=0, rx_data=8'h00, rx_rdy=0, frm_err=0, ovr=0.
- rx passes through SYNC_STAGES flops; all decisions use the last stage, rx_s.
- bd_cnt is 12 bits wide; it is cleared on every state transition and at every sample point.
- bit_cnt is 4 bits wide.
- State IDLE:
  - bd_cnt held at 0.
  - rx_s==0 -> START.
- State START:
  - At bd_cnt==BAUD_TIME/2-1, sample rx_s.
  - Sample 1 (glitch) -> IDLE, no flag change.
  - Sample 0 -> DATA, bit_cnt=0.
- State DATA:
  - At bd_cnt==BAUD_TIME-1, shift = {rx_s, shift[7:1]} and bit_cnt++.
  - The sample that makes bit_cnt reach 8 -> STOP.
- State STOP, at bd_cnt==BAUD_TIME-1, sample rx_s:
  - rx_s==1: next cycle rx_data=shift, rx_rdy=1, frm_err=0; if rx_rdy was already 1 and clr_rdy is low that cycle, ovr=1. -> IDLE.
  - rx_s==0: rx_data and rx_rdy unchanged, frm_err=1. -> BREAK.
- State BREAK:
  - Wait for rx_s==1, then -> IDLE.
  - A held-low line (break) yields exactly one frm_err event and no spurious frames.
- Timing from the first clk where rx_s==0 in IDLE (cycle t):
  - Start-bit check at t+BAUD_TIME/2.
  - Data bit i (0..7) sampled at t+BAUD_TIME/2+(i+1)*BAUD_TIME.
  - Stop sampled at t+BAUD_TIME/2+9*BAUD_TIME.
  - rx_rdy rises one cycle later.
  - Total pin-to-ready latency adds SYNC_STAGES cycles.
- clr_rdy:
  - clr_rdy=1 clears rx_rdy and ovr on the next edge.
  - If clr_rdy coincides with a good-stop completion, the new byte wins: rx_rdy=1, ovr=0 (the old byte counts as consumed).
- frm_err updates only at stop sampling; clr_rdy does not clear it.
- Back-to-back frames: IDLE is re-entered at mid-stop bit, so a start edge arriving immediately after the stop bit is detected with no lost frame.
- rst asserted mid-frame: abort on that edge, all state returns to reset values, and the partial byte is discarded.
- Outputs are registered; no combinational path from rx or clr_rdy to any output.

Test Plan:
- BAUD_TIME=16. Drive frame 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) -> rx_rdy rises 2+8+144+1 cycles after the falling edge; rx_data=8'hA5; frm_err=0; ovr=0.
- Default BAUD_TIME. Loop uart_tx to uart_rx, send 0x00, 0xFF, 0x55, 0x80 back-to-back, pulsing clr_rdy after each byte -> each byte received in order; ovr never set.
- BAUD_TIME=16. Drive a 0 pulse of 6 cycles on idle rx -> no rx_rdy, no frm_err, state returns to IDLE.
- Send 0x3C with stop bit=0, then hold rx low for 40 bit times, then release -> frm_err=1, rx_rdy stays 0, rx_data unchanged; a subsequent good frame 0x12 gives rx_rdy=1, rx_data=8'h12, frm_err=0.
- Send 0x11 and do not ack, then send 0x22 -> rx_data=8'h22, rx_rdy=1, ovr=1. Pulse clr_rdy -> rx_rdy=0, ovr=0. Repeat with clr_rdy asserted on the completion cycle -> rx_rdy=1, ovr=0.
- Assert rst for 1 cycle during data bit 4 of a frame, then send 0x7E -> all outputs zero after reset; only 0x7E is reported.
